divisor_param: RTL

- Parametrised successor to the team's fixed-width sequential divider.
- Performs iterative radix-2 restoring division, one quotient bit per clock.
- Adds a run-time signed/unsigned mode, a divide-by-zero flag and a busy indicator.
- Drives the same start/done handshake used by the existing divider bench.

---
 rtl/divisor_param_if.sv | 25 ++
 rtl/divisor_param.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/divisor_param_if.sv
// Start/done handshake bundle for the parametrised sequential divider.
// The requester uses the master modport and the divider uses the slave modport.
interface divisor_param_if #(
  parameter int unsigned SIZE = 32
);
  logic            start;
  logic            signed_mode;
  logic [SIZE-1:0] numerador;
  logic [SIZE-1:0] denominador;
  logic [SIZE-1:0] cociente;
  logic [SIZE-1:0] resto;
  logic            done;
  logic            busy;
  logic            div_zero;

  modport master (
    output start, signed_mode, numerador, denominador,
    input  cociente, resto, done, busy, div_zero
  );

  modport slave (
    input  start, signed_mode, numerador, denominador,
    output cociente, resto, done, busy, div_zero
  );
endinterface

// File: rtl/divisor_param.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Supports signed/unsigned mode at run time and flags division by zero.
module divisor_param #(
  parameter int unsigned SIZE = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  divisor_param_if.slave   bus
);
  localparam int unsigned CW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            smode_q, smode_d;
  logic            nneg_q, nneg_d;
  logic            dneg_q, dneg_d;
  logic            zero_q, zero_d;
  logic [SIZE-1:0] dvd_q, dvd_d;
  logic [SIZE-1:0] dsr_q, dsr_d;
  logic [SIZE-1:0] rem_q, rem_d;
  logic [SIZE-1:0] cociente_q, cociente_d;
  logic [SIZE-1:0] resto_q, resto_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            div_zero_q, div_zero_d;

  logic            num_neg_c, den_neg_c;
  logic [SIZE-1:0] num_mag_c, den_mag_c;
  logic [SIZE:0]   partial_c, diff_c;
  logic [SIZE-1:0] q_fix_c, r_fix_c;

  // Operand magnitudes; the most negative value maps to 2^(SIZE-1) as unsigned.
  assign num_neg_c = bus.signed_mode & bus.numerador[SIZE-1];
  assign den_neg_c = bus.signed_mode & bus.denominador[SIZE-1];
  assign num_mag_c = num_neg_c ? (~bus.numerador + SIZE'(1))   : bus.numerador;
  assign den_mag_c = den_neg_c ? (~bus.denominador + SIZE'(1)) : bus.denominador;

  // The dividend register shifts out its MSB and shifts in quotient bits.
  assign partial_c = {rem_q, dvd_q[SIZE-1]};
  assign diff_c    = partial_c - {1'b0, dsr_q};

  // Truncating division: remainder follows the dividend sign.
  assign q_fix_c = (smode_q & (nneg_q ^ dneg_q)) ? (~dvd_q + SIZE'(1)) : dvd_q;
  assign r_fix_c = (smode_q & nneg_q)            ? (~rem_q + SIZE'(1)) : rem_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    smode_d    = smode_q;
    nneg_d     = nneg_q;
    dneg_d     = dneg_q;
    zero_d     = zero_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    cociente_d = cociente_q;
    resto_d    = resto_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          smode_d    = bus.signed_mode;
          nneg_d     = num_neg_c;
          dneg_d     = den_neg_c;
          dvd_d      = num_mag_c;
          dsr_d      = den_mag_c;
          rem_d      = '0;
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          zero_d     = (bus.denominador == '0);
          cnt_d      = CW'(SIZE - 1);
          if (bus.denominador == '0) begin
            // Park the dividend magnitude as the remainder so FIX restores the raw operand.
            rem_d   = num_mag_c;
            state_d = FIX;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!diff_c[SIZE]) begin
          rem_d = diff_c[SIZE-1:0];
          dvd_d = {dvd_q[SIZE-2:0], 1'b1};
        end else begin
          rem_d = partial_c[SIZE-1:0];
          dvd_d = {dvd_q[SIZE-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (zero_q) begin
          cociente_d = '1;
          div_zero_d = 1'b1;
        end else begin
          cociente_d = q_fix_c;
        end
        resto_d = r_fix_c;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      smode_q    <= 1'b0;
      nneg_q     <= 1'b0;
      dneg_q     <= 1'b0;
      zero_q     <= 1'b0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      cociente_q <= '0;
      resto_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      smode_q    <= smode_d;
      nneg_q     <= nneg_d;
      dneg_q     <= dneg_d;
      zero_q     <= zero_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      rem_q      <= rem_d;
      cociente_q <= cociente_d;
      resto_q    <= resto_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.cociente = cociente_q;
  assign bus.resto    = resto_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.div_zero = div_zero_q;
endmodule
